rd_responder: RTL

Read-side responder for the credit-based lookup path: accepts one read request per cycle on the `rd_addr`/`rd_read` interface and returns `rd_data`/`rd_valid` from an internal register table after a fixed pipeline latency. It sits opposite the credit requester, which sends requests only while it holds free FIFO credits, so the responder never stalls. A side write port loads the table at run time.

---
 rtl/rd_responder_if.sv | 29 ++
 rtl/rd_responder.sv | 89 ++++++++
 2 files changed

// File: rtl/rd_responder_if.sv
// rd_responder_if: read/write bus between the credit requester and rd_responder.
//   master modport (requester): drives rd_addr, rd_read, wr_addr, wr_data, wr_en;
//                               observes rd_data, rd_valid, busy, rd_cnt.
//   slave modport (responder):  the mirror image.
// Signal names follow the block's documented pin names.
interface rd_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_read;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              busy;
  logic [31:0]       rd_cnt;

  modport master (
    output rd_addr, rd_read, wr_addr, wr_data, wr_en,
    input  rd_data, rd_valid, busy, rd_cnt
  );

  modport slave (
    input  rd_addr, rd_read, wr_addr, wr_data, wr_en,
    output rd_data, rd_valid, busy, rd_cnt
  );
endinterface

// File: rtl/rd_responder.sv
// rd_responder: fixed-latency read responder backed by a flop table.
//   aclk    - clock, rising edge
//   reset_p - asynchronous active-high reset; clears table, pipeline and rd_cnt
//   bus     - rd_responder_if.slave:
//               rd_addr/rd_read  request (one per cycle, never stalled)
//               rd_data/rd_valid response, LATENCY cycles later, in order
//               wr_addr/wr_data/wr_en table write port
//               busy   any read in flight
//               rd_cnt accepted-read counter, wraps modulo 2^32
// Optional build macro RD_RESPONDER_FWD_EN: a same-cycle write to the address
// being read is forwarded into the response instead of the old table value.
module rd_responder #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input logic           aclk,
  input logic           reset_p,
  rd_responder_if.slave bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;

  if ((LATENCY < 1) || (LATENCY > 8)) begin : g_latency_check
    $error("rd_responder: LATENCY=%0d is outside 1..8", LATENCY);
  end

  logic [DATA_W-1:0]  table_q [Depth];
  logic [DATA_W-1:0]  rd_word;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY:0]   vld_shift;
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [DATA_W-1:0]  dat_d [LATENCY];
  logic [31:0]        rd_cnt_q, rd_cnt_d;

  // Table storage; a write commits on the edge where wr_en is high.
  always_ff @(posedge aclk or posedge reset_p) begin
    if (reset_p) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        table_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      table_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read word for stage 0: the pre-write table value unless forwarding is built in.
  always_comb begin
    rd_word = table_q[bus.rd_addr];
`ifdef RD_RESPONDER_FWD_EN
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
      rd_word = bus.wr_data;
    end
`endif
  end

  // Stage 0 data only loads on a request so rd_data holds between responses;
  // later stages shift unconditionally.
  always_comb begin
    vld_shift = {vld_q, bus.rd_read};
    vld_d     = vld_shift[LATENCY-1:0];
    dat_d     = dat_q;
    if (bus.rd_read) begin
      dat_d[0] = rd_word;
    end
    for (int unsigned i = 1; i < LATENCY; i++) begin
      dat_d[i] = dat_q[i-1];
    end
    rd_cnt_d = rd_cnt_q + {31'b0, bus.rd_read};
  end

  always_ff @(posedge aclk or posedge reset_p) begin
    if (reset_p) begin
      vld_q    <= '0;
      rd_cnt_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign bus.rd_valid = vld_q[LATENCY-1];
  assign bus.rd_data  = dat_q[LATENCY-1];
  assign bus.busy     = |vld_q;
  assign bus.rd_cnt   = rd_cnt_q;
endmodule
